mdu: RTL and testbench

Multiply/divide unit for the execute stage of the pipelined MIPS core. It runs alongside the combinational ALU and serves the multi-cycle operations the ALU cannot: MULT/MULTU/DIV/DIVU, plus MTHI/MTLO. The block accepts one request per issue and raises `busy` for a fixed latency. It commits results to the architectural HI/LO registers, which the execute stage reads for MFHI/MFLO. The hazard unit stalls any MDU instruction while `busy` or `start` is high.

---
 rtl/mdu_pkg.sv | 45 ++++
 rtl/mdu_timer.sv | 34 +++
 rtl/mdu.sv | 139 +++++++++++++
 tb/tb_mdu.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op-code constants and op classification for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate ops 7-10).
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_MUL,
    CLS_DIV,
    CLS_MOVE
  } op_class_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU: op_class = CLS_MUL;
      OP_DIV, OP_DIVU:   op_class = CLS_DIV;
      OP_MTHI, OP_MTLO:  op_class = CLS_MOVE;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_class = CLS_MUL;
`endif
      default:           op_class = CLS_NONE;
    endcase
  endfunction

  function automatic logic op_signed(input logic [3:0] op);
    op_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_timer.sv
// Latency down-counter for the MDU: loads the op latency and pulses done
// in the cycle whose closing edge takes the count to zero.
module mdu_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency MULT/DIV family plus MTHI/MTLO, committing to HI/LO.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulation.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  logic               is_signed;
  logic signed [63:0] mul_a, mul_b, prod;
  logic [63:0]        mul_res;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag, b_safe, q_mag, r_mag, div_q, div_r;

  mdu_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Results are formed from the latched operands only; hi/lo change only at commit.
  always_comb begin
    is_signed = op_signed(op_q);
    mul_a     = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    mul_b     = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod      = mul_a * mul_b;
    mul_res   = prod;
`ifdef MDU_MADD_EN
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi_q, lo_q} - prod;
      default:           mul_res = prod;
    endcase
`endif
    a_neg  = is_signed & a_q[31];
    b_neg  = is_signed & b_q[31];
    a_mag  = a_neg ? (32'd0 - a_q) : a_q;
    b_mag  = b_neg ? (32'd0 - b_q) : b_q;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    // Magnitude divide, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. 0x80000000 / -1 wraps to 0x80000000.
    div_q  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    div_r  = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_class(op))
            CLS_MUL, CLS_DIV: begin
              tmr_load = 1'b1;
              tmr_val  = (op_class(op) == CLS_MUL) ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
              op_d     = op;
              a_d      = rs;
              b_d      = rt;
              state_d  = ST_RUN;
            end
            CLS_MOVE: begin
              if (op == OP_MTHI) hi_d = rs;
              else               lo_d = rs;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
          if (op_class(op_q) == CLS_MUL) begin
            {hi_d, lo_d} = mul_res;
          end else if (b_q != 32'd0) begin
            hi_d = div_r;
            lo_d = div_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand/op latches are qualified by the FSM, so they need no reset.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: driver pushes model results, a busy-falling monitor checks commits.
module tb_mdu;

  localparam int MULN = 5;
  localparam int DIVN = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs = 32'd0;
  logic [31:0] rt = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  mdu #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mh = 32'd0;
  logic [31:0] ml = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // 0 none, 1 multiply-class, 2 divide-class, 3 move
  function automatic int tb_cls(input logic [3:0] o);
    if (o == 4'd1 || o == 4'd2) return 1;
    if (o == 4'd3 || o == 4'd4) return 2;
    if (o == 4'd5 || o == 4'd6) return 3;
`ifdef MDU_MADD_EN
    if (o >= 4'd7 && o <= 4'd10) return 1;
`endif
    return 0;
  endfunction

  // Monitor: a commit is the first negedge with busy low after busy was high.
  initial begin
    int   cnt = 0;
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cnt  = 0;
        prev = 1'b0;
      end else begin
        if (busy) begin
          cnt++;
        end else if (prev) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit actual=hi:%h lo:%h required=no commit", hi, lo);
          end else begin
            e = sb.pop_front();
            chk("commit_hi", hi, e.hi);
            chk("commit_lo", lo, e.lo);
            chk("busy_cycles", cnt, e.n);
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int          k;
    int          c;
    logic [63:0] p, acc;
    longint      sa, sbv, q, r;
    exp_t        e;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=busy required=idle");
    end
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 4'd0;
    c = tb_cls(o);
    if (c == 1) begin
      if (o == 4'd1 || o == 4'd7 || o == 4'd9) begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        p   = sa * sbv;
      end else begin
        p = {32'd0, a} * {32'd0, b};
      end
      acc = {mh, ml};
      if (o == 4'd7 || o == 4'd8) p = acc + p;
      if (o == 4'd9 || o == 4'd10) p = acc - p;
      {mh, ml} = p;
      e.hi = mh; e.lo = ml; e.n = MULN;
      sb.push_back(e);
    end else if (c == 2) begin
      if (b != 32'd0) begin
        if (o == 4'd3) begin
          sa  = longint'($signed(a));
          sbv = longint'($signed(b));
        end else begin
          sa  = longint'({32'd0, a});
          sbv = longint'({32'd0, b});
        end
        q  = sa / sbv;
        r  = sa % sbv;
        ml = q[31:0];
        mh = r[31:0];
      end
      e.hi = mh; e.lo = ml; e.n = DIVN;
      sb.push_back(e);
    end else begin
      if (c == 3) begin
        if (o == 4'd5) mh = a;
        else           ml = a;
      end
      chk("noop_busy", {31'd0, busy}, 32'd0);
      chk("move_hi", hi, mh);
      chk("move_lo", lo, ml);
    end
  endtask

  // Start strobe while busy: must be ignored, so the model is untouched.
  task automatic poke(input logic [3:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 4'd0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  o;
    logic [31:0] a, b;
    #3 reset = 1'b0;
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Abort mid-operation: async reset clears everything before any edge.
    issue(4'd5, 32'h55, 32'd0);
    issue(4'd1, 32'd7, 32'd9);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    sb.delete();
    mh = 32'd0;
    ml = 32'd0;
    @(posedge clk);
    #2 reset = 1'b1;

    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(4'd5, 32'h1234, 32'd0);
    issue(4'd6, 32'h5678, 32'd0);
    issue(4'd3, 32'd99, 32'd0);
    wait_idle();
    chk("div0_hi", hi, 32'h1234);
    chk("div0_lo", lo, 32'h5678);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    issue(4'd4, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    poke(4'd6, 32'hAAAA);
    issue(4'd2, 32'h1_0000, 32'h1_0000);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);
    wait_idle();
    chk("b2b_hi", hi, 32'd1);
    chk("b2b_lo", lo, 32'd0);

    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      issue(o, a, b);
      if (tb_cls(o) == 1 || tb_cls(o) == 2) begin
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          if (busy) poke(4'($urandom_range(0, 15)), $urandom);
        end
      end
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("final_hi", hi, mh);
    chk("final_lo", lo, ml);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
